load_sequencer: RTL and testbench
=================================

LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 Parameter: INPUT_WORDS, default 8, number of 32-bit input words per group (fills the 256-bit input shift buffer).
REQ-002 Parameter: WEIGHT_WORDS, default 1, number of 32-bit weight words per group.
REQ-003 Parameter: GRP_W, default 8, width of the group-count field.
REQ-004 Single clock domain; reset asynchronous, active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start_i  in  1  one-cycle job start request.
REQ-008 num_groups_i  in  GRP_W  group count, sampled on accepted start.
REQ-009 abort_i  in  1  cancel the current job.
REQ-010 s_valid_i  in  1  upstream word valid.
REQ-011 s_data_i  in  32  upstream word.
REQ-012 s_ready_o  out  1  upstream ready.
REQ-013 load_en_o  out  1  write strobe to the dataload block.
REQ-014 load_type_o  out  1  0 = weight, 1 = input.
REQ-015 load_data_o  out  32  word to the dataload block.
REQ-016 grp_ready_o  out  1  group loaded; held until acknowledged.
REQ-017 grp_ack_i  in  1  compute consumer has finished with the group.
REQ-018 busy_o  out  1  high in every state except IDLE.
REQ-019 done_o  out  1  one-cycle pulse at job completion.

Function
REQ-020 States: IDLE, LOAD_W, LOAD_I, WAIT_ACK, DONE.
REQ-021 IDLE: start_i with num_groups_i > 0 latches the count and goes to LOAD_W; with num_groups_i == 0 it goes to DONE.
REQ-022 start_i outside IDLE is ignored.
REQ-023 s_ready_o is high only in LOAD_W and LOAD_I; a word transfers when s_valid_i and s_ready_o are both high.
REQ-024 Each transfer registers load_en_o=1, load_data_o=s_data_i, and load_type_o (0 in LOAD_W, 1 in LOAD_I); these appear on the next cycle, a latency of exactly 1.
REQ-025 Without a transfer, load_en_o is 0 on the next cycle; load_data_o and load_type_o hold their values.
REQ-026 A word counter counts transfers within the phase.
  - LOAD_W moves to LOAD_I on the WEIGHT_WORDS-th transfer.
  - LOAD_I moves to WAIT_ACK on the INPUT_WORDS-th transfer.
  - The counter clears on each phase change.
REQ-027 grp_ready_o is registered high on entry to WAIT_ACK and stays high until grp_ack_i.
REQ-028 WAIT_ACK with grp_ack_i decrements the remaining-group counter.
  - If it reaches 0, go to DONE.
  - Otherwise go to LOAD_W.
REQ-029 grp_ack_i outside WAIT_ACK is ignored.
REQ-030 DONE lasts exactly one cycle with done_o=1, then goes to IDLE.
REQ-031 abort_i in any non-IDLE state goes to IDLE on the next cycle.
  - Clears counters and grp_ready_o; done_o stays 0.
  - A transfer accepted in the abort cycle is still emitted on load_en_o.
  - abort_i has priority over grp_ack_i and transfer-driven transitions.
REQ-032 Upstream stalls (s_valid_i low) hold state and counters indefinitely.

Reset
REQ-033 Asserting rst forces state IDLE and clears all counters immediately.
REQ-034 While reset is asserted, every output is 0: s_ready_o, load_en_o, load_type_o, load_data_o, grp_ready_o, busy_o, done_o.
REQ-035 Reset mid-job discards the job; no done_o pulse is produced.

Structure
REQ-036 The shared package holds the state enum, the LOAD_WEIGHT=0 / LOAD_INPUT=1 load-type constants, and the default INPUT_WORDS/WEIGHT_WORDS values.
REQ-037 The block instantiates one sub-module, dataload_word_counter (a parameterised up-counter with clear and terminal-count flag), for the per-phase word count.
REQ-038 The outputs connect directly to dataload load_en_i / load_type / data_i.

Verification
REQ-039 Scenario 1 (normal job): start with num_groups=1 and continuous valid words 0x1..0x9 -> one load_en with type 0 carrying 0x1, then 8 with type 1 carrying 0x2..0x9, each one cycle after its transfer; grp_ready rises; ack -> done pulse -> IDLE.
REQ-040 Scenario 2 (two groups): num_groups=2 -> 18 transfers in W,I×8,W,I×8 order; second load_en burst only after the first ack; exactly one done pulse.
REQ-041 Scenario 3 (stall and zero count): s_valid low for 5 cycles mid-LOAD_I -> no load_en, counter holds, resume completes with exactly 8 input words; separately, start with num_groups=0 -> done pulse 1 cycle later with no load_en.
REQ-042 Scenario 4 (abort): abort after the 3rd input word -> IDLE next cycle, s_ready low, no grp_ready, no done; a new start then loads a full group correctly.
REQ-043 Scenario 5 (reset mid-WAIT_ACK and ignored inputs): rst asserted -> all outputs 0 asynchronously; start while busy and ack outside WAIT_ACK have no effect.

Source files
------------

// File: rtl/load_sequencer_pkg.sv
// Shared types and constants for the load sequencer and its word counter.
package load_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_W   = 3'd1,
        ST_LOAD_I   = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic LOAD_WEIGHT = 1'b0;
    localparam logic LOAD_INPUT  = 1'b1;

    localparam int DEF_INPUT_WORDS  = 8;
    localparam int DEF_WEIGHT_WORDS = 1;

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dataload_word_counter.sv
// Per-phase word counter: counts accepted words, flags the last one of a phase.
module dataload_word_counter
    import load_sequencer_pkg::*;
#(
    parameter int MAX_COUNT = DEF_INPUT_WORDS,
    parameter int CW        = cnt_width(MAX_COUNT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic [CW-1:0] last,
    output logic          tc
);

    logic [CW-1:0] count;

    // Count up on each increment; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end

    // Terminal count is asserted in the cycle the final word of the phase is taken.
    always_comb begin
        tc = inc && (count == last);
    end

endmodule

// File: rtl/load_sequencer.sv
// Streams weight then input words per group into the dataload block,
// hands each loaded group to the compute side and waits for its ack.
module load_sequencer
    import load_sequencer_pkg::*;
#(
    parameter int INPUT_WORDS  = DEF_INPUT_WORDS,
    parameter int WEIGHT_WORDS = DEF_WEIGHT_WORDS,
    parameter int GRP_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [GRP_W-1:0] num_groups_i,
    input  logic             abort_i,
    input  logic             s_valid_i,
    input  logic [31:0]      s_data_i,
    output logic             s_ready_o,
    output logic             load_en_o,
    output logic             load_type_o,
    output logic [31:0]      load_data_o,
    output logic             grp_ready_o,
    input  logic             grp_ack_i,
    output logic             busy_o,
    output logic             done_o
);

    localparam int MAX_WORDS = (INPUT_WORDS > WEIGHT_WORDS) ? INPUT_WORDS : WEIGHT_WORDS;
    localparam int CW        = cnt_width(MAX_WORDS);

    state_t           state, state_nxt;
    logic             xfer;
    logic             phase_last;
    logic             cnt_clr;
    logic [CW-1:0]    cnt_last;
    logic [GRP_W-1:0] grp_rem;

    assign xfer = s_valid_i && s_ready_o;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: phase advances on terminal count, abort overrides everything.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start_i) state_nxt = (num_groups_i != '0) ? ST_LOAD_W : ST_DONE;
            ST_LOAD_W:   if (phase_last) state_nxt = ST_LOAD_I;
            ST_LOAD_I:   if (phase_last) state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: if (grp_ack_i) state_nxt = (grp_rem == GRP_W'(1)) ? ST_DONE : ST_LOAD_W;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
        if (abort_i && state != ST_IDLE)
            state_nxt = ST_IDLE;
    end

    // State-decoded outputs; all zero in IDLE, hence during reset.
    always_comb begin
        s_ready_o = (state == ST_LOAD_W) || (state == ST_LOAD_I);
        busy_o    = (state != ST_IDLE);
        done_o    = (state == ST_DONE);
    end

    // Word counter restarts on any state change, including abort.
    always_comb begin
        cnt_clr  = (state_nxt != state);
        cnt_last = (state == ST_LOAD_W) ? CW'(WEIGHT_WORDS - 1) : CW'(INPUT_WORDS - 1);
    end

    dataload_word_counter #(
        .MAX_COUNT (MAX_WORDS),
        .CW        (CW)
    ) u_word_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (xfer),
        .last (cnt_last),
        .tc   (phase_last)
    );

    // Remaining-group count: loaded on start, stepped down per acked group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            grp_rem <= '0;
        else if (state == ST_IDLE && start_i)
            grp_rem <= num_groups_i;
        else if (abort_i && state != ST_IDLE)
            grp_rem <= '0;
        else if (state == ST_WAIT_ACK && grp_ack_i)
            grp_rem <= grp_rem - 1'b1;
    end

    // Register each accepted word toward the dataload block (one-cycle latency).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_en_o   <= 1'b0;
            load_type_o <= LOAD_WEIGHT;
            load_data_o <= '0;
        end else begin
            load_en_o <= xfer;
            if (xfer) begin
                load_data_o <= s_data_i;
                load_type_o <= (state == ST_LOAD_I) ? LOAD_INPUT : LOAD_WEIGHT;
            end
        end
    end

    // Group-ready mirrors residency in WAIT_ACK, registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            grp_ready_o <= 1'b0;
        else
            grp_ready_o <= (state_nxt == ST_WAIT_ACK);
    end

endmodule

// File: tb/tb_load_sequencer.sv
// Bench for load_sequencer: cycle table for a single-group job, then
// scenario sequences with a scoreboard on the dataload write port.
module tb_load_sequencer;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [7:0]  num_groups_i;
    logic        abort_i;
    logic        s_valid_i;
    logic [31:0] s_data_i;
    logic        s_ready_o;
    logic        load_en_o;
    logic        load_type_o;
    logic [31:0] load_data_o;
    logic        grp_ready_o;
    logic        grp_ack_i;
    logic        busy_o;
    logic        done_o;

    load_sequencer #(.INPUT_WORDS(8), .WEIGHT_WORDS(1), .GRP_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .num_groups_i (num_groups_i),
        .abort_i      (abort_i),
        .s_valid_i    (s_valid_i),
        .s_data_i     (s_data_i),
        .s_ready_o    (s_ready_o),
        .load_en_o    (load_en_o),
        .load_type_o  (load_type_o),
        .load_data_o  (load_data_o),
        .grp_ready_o  (grp_ready_o),
        .grp_ack_i    (grp_ack_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        typ;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    logic sb_en    = 1'b0;
    logic drv_type = 1'b0;
    logic acc_pend;
    exp_t acc_exp;

    always @(negedge clk) begin
        acc_pend <= s_valid_i && s_ready_o;
        acc_exp  <= '{typ: drv_type, data: s_data_i};
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done_o) done_cnt++;
        if (sb_en) begin
            if (acc_pend) q.push_back(acc_exp);
            if (acc_pend || load_en_o) begin
                chk("load_en_latency", {31'd0, load_en_o}, {31'd0, acc_pend});
                if (load_en_o && q.size() > 0) begin
                    e = q.pop_front();
                    chk("sb_type", {31'd0, load_type_o}, {31'd0, e.typ});
                    chk("sb_data", load_data_o, e.data);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [31:0] d, input logic t);
        bit ok;
        ok = 0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        drv_type  = t;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (s_ready_o) ok = 1;
            @(posedge clk);
            #2;
        end
        s_valid_i = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_group(input logic [31:0] base);
        send_word(base, 1'b0);
        for (int k = 1; k <= 8; k++) send_word(base + k, 1'b1);
    endtask

    task automatic start_job(input logic [7:0] n);
        start_i      = 1'b1;
        num_groups_i = n;
        step();
        start_i      = 1'b0;
        num_groups_i = 8'd0;
    endtask

    task automatic ack_pulse();
        grp_ack_i = 1'b1;
        step();
        grp_ack_i = 1'b0;
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic        start;
        logic [7:0]  ng;
        logic        valid;
        logic [31:0] data;
        logic        ack;
        logic        ready;
        logic        en;
        logic        typ;
        logic [31:0] ldata;
        logic        grdy;
        logic        busy;
        logic        done;
    } vec_t;

    function automatic vec_t mk(logic st, logic [7:0] ng, logic v, logic [31:0] d, logic a,
                                logic rdy, logic en, logic ty, logic [31:0] ld,
                                logic gr, logic bz, logic dn);
        vec_t r;
        r.start = st; r.ng = ng; r.valid = v; r.data = d; r.ack = a;
        r.ready = rdy; r.en = en; r.typ = ty; r.ldata = ld;
        r.grdy = gr; r.busy = bz; r.done = dn;
        return r;
    endfunction

    vec_t tbl[13];

    initial begin
        int d0;
        rst = 1'b1; start_i = 1'b0; num_groups_i = 8'd0; abort_i = 1'b0;
        s_valid_i = 1'b0; s_data_i = 32'd0; grp_ack_i = 1'b0;

        // Reset state.
        #3;
        chk("rst_s_ready",   {31'd0, s_ready_o},   32'd0);
        chk("rst_load_en",   {31'd0, load_en_o},   32'd0);
        chk("rst_load_type", {31'd0, load_type_o}, 32'd0);
        chk("rst_load_data", load_data_o,          32'd0);
        chk("rst_grp_ready", {31'd0, grp_ready_o}, 32'd0);
        chk("rst_busy",      {31'd0, busy_o},      32'd0);
        chk("rst_done",      {31'd0, done_o},      32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Scenario 1 as an explicit cycle table.
        tbl[0] = mk(1, 8'd1, 0, 32'd0, 0,  1, 0, 0, 32'd0, 0, 1, 0);
        tbl[1] = mk(0, 8'd0, 1, 32'd1, 0,  1, 1, 0, 32'd1, 0, 1, 0);
        for (int i = 2; i <= 8; i++)
            tbl[i] = mk(0, 8'd0, 1, 32'(i), 0,  1, 1, 1, 32'(i), 0, 1, 0);
        tbl[9]  = mk(0, 8'd0, 1, 32'd9, 0,  0, 1, 1, 32'd9, 1, 1, 0);
        tbl[10] = mk(0, 8'd0, 0, 32'd0, 0,  0, 0, 1, 32'd9, 1, 1, 0);
        tbl[11] = mk(0, 8'd0, 0, 32'd0, 1,  0, 0, 1, 32'd9, 0, 1, 1);
        tbl[12] = mk(0, 8'd0, 0, 32'd0, 0,  0, 0, 1, 32'd9, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            start_i = tbl[i].start; num_groups_i = tbl[i].ng;
            s_valid_i = tbl[i].valid; s_data_i = tbl[i].data; grp_ack_i = tbl[i].ack;
            @(posedge clk); #1;
            chk($sformatf("t%0d_s_ready", i),   {31'd0, s_ready_o},   {31'd0, tbl[i].ready});
            chk($sformatf("t%0d_load_en", i),   {31'd0, load_en_o},   {31'd0, tbl[i].en});
            chk($sformatf("t%0d_load_type", i), {31'd0, load_type_o}, {31'd0, tbl[i].typ});
            chk($sformatf("t%0d_load_data", i), load_data_o,          tbl[i].ldata);
            chk($sformatf("t%0d_grp_ready", i), {31'd0, grp_ready_o}, {31'd0, tbl[i].grdy});
            chk($sformatf("t%0d_busy", i),      {31'd0, busy_o},      {31'd0, tbl[i].busy});
            chk($sformatf("t%0d_done", i),      {31'd0, done_o},      {31'd0, tbl[i].done});
            #1;
        end
        start_i = 1'b0; num_groups_i = 8'd0; s_valid_i = 1'b0; grp_ack_i = 1'b0;
        sb_en = 1'b1;

        // Scenario 2: two groups, second burst gated by the first ack.
        d0 = done_cnt;
        start_job(8'd2);
        send_group(32'h1000);
        chk("s2_grp_ready", {31'd0, grp_ready_o}, 32'd1);
        s_valid_i = 1'b1; s_data_i = 32'hDEAD; drv_type = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s2_hold_s_ready", {31'd0, s_ready_o}, 32'd0);
        end
        s_valid_i = 1'b0;
        ack_pulse();
        chk("s2_ack_grp_ready", {31'd0, grp_ready_o}, 32'd0);
        chk("s2_ack_s_ready",   {31'd0, s_ready_o},   32'd1);
        send_group(32'h2000);
        ack_pulse();
        chk("s2_done", {31'd0, done_o}, 32'd1);
        step(); step();
        chk("s2_done_count", 32'(done_cnt), 32'(d0 + 1));
        chk("s2_idle", {31'd0, busy_o}, 32'd0);

        // Scenario 3a: stall mid-LOAD_I.
        start_job(8'd1);
        send_word(32'h100, 1'b0);
        for (int k = 1; k <= 3; k++) send_word(32'h100 + k, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("s3_stall_s_ready",   {31'd0, s_ready_o},   32'd1);
            chk("s3_stall_grp_ready", {31'd0, grp_ready_o}, 32'd0);
        end
        for (int k = 4; k <= 7; k++) send_word(32'h100 + k, 1'b1);
        chk("s3_7words_grp_ready", {31'd0, grp_ready_o}, 32'd0);
        send_word(32'h108, 1'b1);
        chk("s3_8words_grp_ready", {31'd0, grp_ready_o}, 32'd1);
        ack_pulse();
        chk("s3_done", {31'd0, done_o}, 32'd1);
        step();

        // Scenario 3b: zero groups completes immediately.
        d0 = done_cnt;
        start_job(8'd0);
        chk("s3_zero_done", {31'd0, done_o}, 32'd1);
        chk("s3_zero_busy", {31'd0, busy_o}, 32'd1);
        step();
        chk("s3_zero_done_after", {31'd0, done_o}, 32'd0);
        chk("s3_zero_idle",       {31'd0, busy_o}, 32'd0);
        chk("s3_zero_done_count", 32'(done_cnt), 32'(d0 + 1));

        // Scenario 4: abort after the third input word, with a word in the abort cycle.
        d0 = done_cnt;
        start_job(8'd1);
        send_word(32'h200, 1'b0);
        for (int k = 1; k <= 3; k++) send_word(32'h200 + k, 1'b1);
        abort_i = 1'b1; s_valid_i = 1'b1; s_data_i = 32'h204; drv_type = 1'b1;
        step();
        abort_i = 1'b0; s_valid_i = 1'b0;
        chk("s4_abort_busy",      {31'd0, busy_o},      32'd0);
        chk("s4_abort_s_ready",   {31'd0, s_ready_o},   32'd0);
        chk("s4_abort_grp_ready", {31'd0, grp_ready_o}, 32'd0);
        chk("s4_abort_done",      {31'd0, done_o},      32'd0);
        step(); step();
        chk("s4_abort_no_done", 32'(done_cnt), 32'(d0));
        start_job(8'd1);
        send_group(32'h300);
        chk("s4_restart_grp_ready", {31'd0, grp_ready_o}, 32'd1);
        ack_pulse();
        chk("s4_restart_done", {31'd0, done_o}, 32'd1);
        step();

        // Scenario 5a: start while busy and ack outside WAIT_ACK are ignored.
        start_job(8'd1);
        send_word(32'h400, 1'b0);
        send_word(32'h401, 1'b1);
        send_word(32'h402, 1'b1);
        start_i = 1'b1; num_groups_i = 8'd5;
        send_word(32'h403, 1'b1);
        start_i = 1'b0; num_groups_i = 8'd0;
        grp_ack_i = 1'b1;
        send_word(32'h404, 1'b1);
        grp_ack_i = 1'b0;
        chk("s5_ack_ignored_grp_ready", {31'd0, grp_ready_o}, 32'd0);
        for (int k = 5; k <= 8; k++) send_word(32'h400 + k, 1'b1);
        chk("s5_grp_ready", {31'd0, grp_ready_o}, 32'd1);
        ack_pulse();
        chk("s5_single_group_done", {31'd0, done_o}, 32'd1);
        step();

        // Scenario 5b: asynchronous reset while waiting for ack.
        start_job(8'd1);
        send_group(32'h500);
        chk("s5_pre_rst_grp_ready", {31'd0, grp_ready_o}, 32'd1);
        d0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        chk("s5_rst_s_ready",   {31'd0, s_ready_o},   32'd0);
        chk("s5_rst_load_en",   {31'd0, load_en_o},   32'd0);
        chk("s5_rst_load_type", {31'd0, load_type_o}, 32'd0);
        chk("s5_rst_load_data", load_data_o,          32'd0);
        chk("s5_rst_grp_ready", {31'd0, grp_ready_o}, 32'd0);
        chk("s5_rst_busy",      {31'd0, busy_o},      32'd0);
        chk("s5_rst_done",      {31'd0, done_o},      32'd0);
        step(); step();
        rst = 1'b0;
        step(); step();
        chk("s5_post_rst_busy",    {31'd0, busy_o}, 32'd0);
        chk("s5_post_rst_no_done", 32'(done_cnt),   32'(d0));

        step();
        chk("sb_queue_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
